delay_line_ctrl: RTL and testbench



---
 rtl/delay_line_ctrl_pkg.sv | 23 ++
 rtl/delay_line_ctrl_if.sv | 35 +++
 rtl/delay_line_store.sv | 29 ++
 rtl/delay_line_ctrl.sv | 150 +++++++++++++++
 tb/tb_delay_line_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/delay_line_ctrl_pkg.sv
// delay_line_ctrl_pkg
//   Shared definitions for the programmable delay-line controller:
//   controller state encoding, default geometry and the delay clamp.
//   Optional feature macro used by the controller: DELAY_LINE_CTRL_DROPCNT_EN.
package delay_line_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 32;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_e;

  // A zero delay would need a bypass path; one sample is the minimum.
  function automatic int unsigned clamp_delay(int unsigned req, int unsigned depth);
    if (req == 0) return 1;
    if (req > depth) return depth;
    return req;
  endfunction

endpackage

// File: rtl/delay_line_ctrl_if.sv
// delay_line_ctrl_if
//   Bundles the configuration, sample-in, sample-out and status signals
//   of delay_line_ctrl.
//   master: cfg_delay, cfg_load, in_valid, in_data driven; the rest observed.
//   slave : the controller side (in_ready, out_valid, out_data, state,
//           drop_cnt driven).
interface delay_line_ctrl_if
  import delay_line_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    cfg_delay;
  logic             cfg_load;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       state;
  logic [7:0]       drop_cnt;

  modport master (
    output cfg_delay, cfg_load, in_valid, in_data,
    input  in_ready, out_valid, out_data, state, drop_cnt
  );

  modport slave (
    input  cfg_delay, cfg_load, in_valid, in_data,
    output in_ready, out_valid, out_data, state, drop_cnt
  );

endinterface

// File: rtl/delay_line_store.sv
// delay_line_store
//   WIDTH x DEPTH sample store: one synchronous write port, one read port.
//   A read and a write to the same address in one cycle return the old word.
//   Contents are not reset.
//   Ports: clk, we, waddr, wdata (write side); raddr, rdata (read side).
module delay_line_store #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Combinational read; the controller registers the result, so the
  // write landing on the same edge is never seen by that read.
  assign rdata = mem[raddr];

endmodule

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl
//   Runtime-programmable sample delay built on a circular store.
//   Sequencing: FLUSH (zero the store) -> FILL (collect D samples) -> RUN.
//   Ports: clk, rst_n (async, active-low), bus (delay_line_ctrl_if.slave).
//   Optional: DELAY_LINE_CTRL_DROPCNT_EN builds the saturating drop counter;
//   otherwise drop_cnt is tied to zero.
module delay_line_ctrl
  import delay_line_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  delay_line_ctrl_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    delay_q, delay_d;
  logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             in_ready;
  logic             accept;
  logic             st_we;
  logic [AW-1:0]    st_waddr;
  logic [AW-1:0]    st_raddr;
  logic [WIDTH-1:0] st_wdata;
  logic [WIDTH-1:0] st_rdata;

  assign in_ready = (state_q != FLUSH) && !bus.cfg_load;
  assign accept   = bus.in_valid && in_ready;

  // D == DEPTH truncates to zero offset, i.e. the word about to be overwritten.
  assign st_raddr = wr_ptr_q - delay_q[AW-1:0];

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    fill_cnt_d  = fill_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    st_we       = 1'b0;
    st_waddr    = wr_ptr_q;
    st_wdata    = bus.in_data;

    if (bus.cfg_load) begin
      delay_d     = CW'(clamp_delay(32'(bus.cfg_delay), DEPTH));
      state_d     = FLUSH;
      flush_cnt_d = '0;
    end else begin
      case (state_q)
        FLUSH: begin
          st_we       = 1'b1;
          st_waddr    = flush_cnt_q;
          st_wdata    = '0;
          flush_cnt_d = flush_cnt_q + AW'(1);
          if (flush_cnt_q == AW'(DEPTH - 1)) begin
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
            state_d    = FILL;
          end
        end
        FILL: begin
          if (accept) begin
            st_we      = 1'b1;
            wr_ptr_d   = wr_ptr_q + AW'(1);
            fill_cnt_d = fill_cnt_q + CW'(1);
            if (fill_cnt_q == delay_q - CW'(1)) state_d = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            st_we       = 1'b1;
            wr_ptr_d    = wr_ptr_q + AW'(1);
            out_valid_d = 1'b1;
            out_data_d  = st_rdata;
          end
        end
        default: state_d = FLUSH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FLUSH;
      delay_q     <= CW'(1);
      fill_cnt_q  <= '0;
      flush_cnt_q <= '0;
      wr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      fill_cnt_q  <= fill_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  delay_line_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .we    (st_we),
    .waddr (st_waddr),
    .wdata (st_wdata),
    .raddr (st_raddr),
    .rdata (st_rdata)
  );

`ifdef DELAY_LINE_CTRL_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.in_valid && !in_ready && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = '0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl
//   Randomised-gap stimulus against a sample-history reference model.
//   The driver records expected outputs (with the clock edge they belong to)
//   in a queue; an independent monitor compares after every rising edge.
module tb_delay_line_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned DP = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  delay_line_ctrl_if #(.WIDTH(W), .DEPTH(DP)) bus ();

  delay_line_ctrl #(.WIDTH(W), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    time        t;
    logic [7:0] d;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] hist[$];
  int         flush_left;
  int         dly_m;
  int         acc_m;
  int         drops_m;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 0;
  bit         a;

  function automatic int clampm(int r);
    if (r < 1) return 1;
    if (r > int'(DP)) return int'(DP);
    return r;
  endfunction

  // Samples accepted since the last flush decide FILL versus RUN.
  function automatic int model_state();
    if (flush_left > 0) return 0;
    if (acc_m < dly_m) return 1;
    return 2;
  endfunction

  function automatic int exp_drops();
`ifdef DELAY_LINE_CTRL_DROPCNT_EN
    return drops_m;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    flush_left = DP;
    dly_m      = 1;
    acc_m      = 0;
    drops_m    = 0;
    hist.delete();
    expq.delete();
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [7:0] d, input bit ld,
                      input int dly, output bit acc);
    bit         rdy;
    logic [7:0] od;
    exp_t       e;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.cfg_load  = ld;
    bus.cfg_delay = 6'(dly);
    rdy = (flush_left == 0) && !ld;
    #1 check("in_ready", longint'(bus.in_ready), longint'(rdy));
    acc = v && rdy;
    @(posedge clk);
    if (v && !rdy && drops_m < 255) drops_m++;
    if (ld) begin
      dly_m      = clampm(dly);
      flush_left = DP;
      acc_m      = 0;
      hist.delete();
    end else if (flush_left > 0) begin
      flush_left--;
    end else if (v) begin
      hist.push_back(d);
      acc_m++;
      if (hist.size() > dly_m) begin
        od  = hist.pop_front();
        e.t = $time;
        e.d = od;
        expq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit x;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 0, x);
  endtask

  task automatic load(input int dly, input bit v);
    bit x;
    step(v, 8'hEE, 1'b1, dly, x);
  endtask

  task automatic send(input int n, input int first, input int gap_pct);
    int sent  = 0;
    int guard = 0;
    bit v;
    bit x;
    while (sent < n && guard < 2000) begin
      v = ($urandom_range(99) >= gap_pct);
      step(v, 8'(first + sent), 1'b0, 0, x);
      if (x) sent++;
      guard++;
    end
    check("send_complete", sent, n);
  endtask

  // Monitor: every rising edge, compare registered outputs with the model.
  initial begin
    time  te;
    exp_t e;
    forever begin
      @(posedge clk);
      te = $time;
      #1;
      if (mon_en) begin
        check("state", longint'(bus.state), model_state());
        check("drop_cnt", longint'(bus.drop_cnt), exp_drops());
        if (expq.size() > 0 && expq[0].t == te) begin
          e = expq.pop_front();
          check("out_valid", longint'(bus.out_valid), 1);
          check("out_data", longint'(bus.out_data), longint'(e.d));
        end else begin
          check("out_valid_idle", longint'(bus.out_valid), 0);
        end
      end
    end
  end

  initial begin
    bus.cfg_load  = 1'b0;
    bus.cfg_delay = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", longint'(bus.in_ready), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_state", longint'(bus.state), 0);
    check("rst_drop_cnt", longint'(bus.drop_cnt), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Post-reset flush: ready low for exactly DEPTH cycles.
    idle(40);

    // D=3, back-to-back 1..10 -> outputs 1..7.
    load(3, 1'b0);
    idle(32);
    send(10, 1, 0);
    idle(3);

    // D=32 with random gaps, 0..79 -> outputs 0..47 across pointer wrap.
    load(32, 1'b0);
    idle(32);
    send(80, 0, 30);

    // Reload mid-RUN with in_valid held high through the flush.
    send(4, 80, 0);
    load(5, 1'b1);
    send(10, 100, 0);
    idle(2);

    // Clamp cases.
    load(0, 1'b0);
    send(5, 50, 20);
    load(40, 1'b0);
    send(40, 150, 10);

    // Reload during FLUSH restarts the full flush.
    load(7, 1'b0);
    idle(10);
    load(7, 1'b0);
    send(9, 60, 0);

    // Drop-counter saturation: 300 cycles of in_valid while loading.
    for (int i = 0; i < 300; i++) step(1'b1, 8'h00, 1'b1, 4, a);
    send(6, 200, 0);

    // Asynchronous reset mid-RUN.
    bus.in_valid = 1'b0;
    bus.cfg_load = 1'b0;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    model_reset();
    #1;
    check("arst_state", longint'(bus.state), 0);
    check("arst_out_valid", longint'(bus.out_valid), 0);
    check("arst_out_data", longint'(bus.out_data), 0);
    check("arst_in_ready", longint'(bus.in_ready), 0);
    check("arst_drop_cnt", longint'(bus.drop_cnt), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(32);
    send(5, 9, 0);
    idle(3);

    check("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
